add_resp_checker: RTL
=====================

Name: add_resp_checker

Overview:
- Downstream consumer of the 4-bit adder DUT.
- Each cycle, when in_valid is high, it samples the operands a, b and the DUT result y, and computes the expected sum.
- It flags any mismatch, keeps running transaction, error and drop counters, and buffers the response records in a small FIFO for readout by the test environment over a valid/ready handshake.

Parameters:
- W, 4, operand/result width (matches the adder ports).
- DEPTH, 4, FIFO record depth; power of two, at least 2.
- CW, 8, width of each counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample in_a/in_b/in_y this cycle.
- in_a  in  W  adder operand a.
- in_b  in  W  adder operand b.
- in_y  in  W  adder result y.
- out_valid  out  1  FIFO head record is valid.
- out_ready  in  1  consumer accepts the head record.
- out_a  out  W  head record operand a.
- out_b  out  W  head record operand b.
- out_y  out  W  head record result y.
- out_mismatch  out  1  head record: y differs from expected sum.
- txn_count  out  CW  accepted-record count.
- err_count  out  CW  accepted mismatching records.
- drop_count  out  CW  records lost to a full FIFO.
- full  out  1  FIFO holds DEPTH records.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO emptied; all outputs are 0 (out_valid, out_a/b/y, out_mismatch, all counters, full). Reset asserted mid-operation discards every buffered record and clears the counters immediately, without waiting for a clock edge.
- Expected sum = (in_a + in_b) mod 2^W, computed in W+1 bits and truncated. mismatch = (in_y != expected sum).
- Pop occurs when out_valid and out_ready are both high at a clock edge; the head advances.
- Push is accepted when in_valid is high and (not full, or a pop happens in the same cycle).
- Simultaneous push and pop when full: both happen; occupancy stays DEPTH and full stays high.
- Simultaneous push and pop when empty: the push is stored; out_valid rises the next cycle (no same-cycle bypass).
- Latency: a record captured at edge N is visible on out_* after edge N, provided the FIFO was empty.
- Dropped push: in_valid is high, the FIFO is full and there is no pop. The record is discarded, drop_count increments, and txn_count and err_count are unchanged.
- Accepted push: txn_count increments; err_count also increments if the record mismatches.
- All counters saturate at 2^CW-1; they never wrap.
- full is registered and equals (occupancy == DEPTH).
- Read/write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked in a separate log2(DEPTH)+1-bit count.
- out_* fields are stable while out_valid is high and out_ready is low.
- Stored records are plain registers with no reset requirement beyond the outputs. out_* reads as 0 whenever out_valid is low.

Optional Feature:
- Macro: ADD_CARRY_FLAG_EN.
- Defined: each record gains a carry bit = bit W of (in_a + in_b), presented on an extra output port out_carry (out, 1, reset 0).
- Undefined: the out_carry port and its storage are absent; all other behaviour is identical.

Decomposition:
- Package add_chk_pkg holds:
  - default W;
  - typedef resp_rec_t (packed struct: a, b, y, mismatch, and carry under the macro);
  - function exp_sum(a, b) returning W+1 bits.
- Sub-module add_chk_fifo: a parameterised synchronous FIFO of resp_rec_t, with push/pop/full/empty and asynchronous active-low reset.
- The top level contains the checker arithmetic, the counters, and the drop logic.

Test Plan:
- Match case, out_ready=1: in_a=4'b0100, in_b=4'b1100, in_y=0 for one cycle -> next cycle out_valid=1, out_mismatch=0, txn_count=1, err_count=0. With ADD_CARRY_FLAG_EN defined, out_carry=1.
- Match then mismatch: (2,5,7) then (5,7,11) -> records show out_mismatch=0 then 1; err_count=1, txn_count=2.
- Overflow, out_ready=0: 5 consecutive valid samples -> full=1 after the 4th; the 5th is dropped, drop_count=1, txn_count=4. After draining, the records come out in order 1..4.
- Full with simultaneous push and pop: FIFO full, in_valid=1 and out_ready=1 together -> no drop, occupancy stays 4, oldest record popped.
- Reset mid-stream: rst_n pulled low between clock edges with 3 records held -> out_valid=0 and all counters 0 immediately. After release, a single push appears one cycle later.
- Saturation, CW=4: 20 accepted mismatching samples -> txn_count=15, err_count=15, with no wrap.

Source files
------------

// File: rtl/add_chk_pkg.sv
// add_chk_pkg: shared width, response record type and reference sum for the adder checker.
// Contents: AW (default operand width), resp_rec_t (a, b, y, mismatch[, carry]), exp_sum().
// Optional feature macro ADD_CARRY_FLAG_EN adds a carry bit to every record.
package add_chk_pkg;
  localparam int AW = 4;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] y;
    logic          mismatch;
`ifdef ADD_CARRY_FLAG_EN
    logic          carry;
`endif
  } resp_rec_t;
  function automatic logic [AW:0] exp_sum(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/add_chk_fifo.sv
// add_chk_fifo: synchronous FIFO of resp_rec_t records.
// Ports: clk, rst_n (async active-low), push/din write, pop reads head, dout = head record,
// full (registered, occupancy == DEPTH), empty (occupancy == 0).
// The caller must only push when not full or popping, and only pop when not empty.
module add_chk_fifo
  import add_chk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  resp_rec_t din,
  output resp_rec_t dout,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  resp_rec_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            full_q, full_d;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;
    full_d   = cnt_d == (PW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end
  // Record storage needs no reset: the head is masked by out_valid at the top level.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/add_resp_checker.sv
// add_resp_checker: checks 4-bit adder responses, counts them and buffers records for readout.
// Inputs: clk, rst_n (async active-low), in_valid/in_a/in_b/in_y sample, out_ready pop.
// Outputs: out_valid + head record (out_a/out_b/out_y/out_mismatch), saturating txn/err/drop
// counters, full. With ADD_CARRY_FLAG_EN defined, out_carry presents the record's carry bit.
module add_resp_checker
  import add_chk_pkg::*;
#(
  parameter int W     = AW,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [W-1:0]  in_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [W-1:0]  out_y,
  output logic          out_mismatch,
`ifdef ADD_CARRY_FLAG_EN
  output logic          out_carry,
`endif
  output logic [CW-1:0] txn_count,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] drop_count,
  output logic          full
);
  logic [W:0]    sum;
  logic          mism, push, pop, drop, empty;
  resp_rec_t     rec, head;
  logic [CW-1:0] txn_q, txn_d, err_q, err_d, drop_q, drop_d;
  always_comb begin
    sum          = exp_sum(in_a, in_b);
    // Mask off the carry so the compare is modulo 2^W.
    mism         = (sum & (W+1)'((1 << W) - 1)) != {1'b0, in_y};
    rec          = '0;
    rec.a        = in_a;
    rec.b        = in_b;
    rec.y        = in_y;
    rec.mismatch = mism;
`ifdef ADD_CARRY_FLAG_EN
    rec.carry    = sum[W];
`endif
    pop          = !empty && out_ready;
    push         = in_valid && (!full || pop);
    drop         = in_valid && full && !pop;
    txn_d        = (push && txn_q != '1) ? txn_q + 1'b1 : txn_q;
    err_d        = (push && mism && err_q != '1) ? err_q + 1'b1 : err_q;
    drop_d       = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q  <= '0;
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      txn_q  <= txn_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end
  add_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rec),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign out_valid    = !empty;
  assign out_a        = out_valid ? head.a : '0;
  assign out_b        = out_valid ? head.b : '0;
  assign out_y        = out_valid ? head.y : '0;
  assign out_mismatch = out_valid && head.mismatch;
`ifdef ADD_CARRY_FLAG_EN
  assign out_carry    = out_valid && head.carry;
`endif
  assign txn_count    = txn_q;
  assign err_count    = err_q;
  assign drop_count   = drop_q;
endmodule
